// File: rtl/quad_in_filter.sv
// Quadrature input conditioner: two-flop synchronisers, prescaled glitch filter,
// and step/dir/err event generation for a downstream quadrature counter.
module quad_in_filter #(
    parameter int unsigned PRESC_BITS = 8,
    parameter int unsigned FILT_LEN   = 4
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESC_BITS-1:0] presc,
    input  logic                  PLUS_A,
    input  logic                  PLUS_B,
    input  logic                  err_clr,
    output logic                  qa,
    output logic                  qb,
    output logic                  step,
    output logic                  dir,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    localparam int unsigned FW = 4;
    localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_a_q, sync_b_q;
    logic [PRESC_BITS-1:0] pcnt_q, pcnt_d;
    logic [FW-1:0]         fcnt_a_q, fcnt_a_d, fcnt_b_q, fcnt_b_d;
    logic [FW-1:0]         icnt_q, icnt_d;
    logic                  pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic                  qa_q, qa_d, qb_q, qb_d;
    logic                  step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic s_a, s_b, active_c, strobe_c, lvl_a_c, lvl_b_c, new_qa_c, new_qb_c;

    assign s_a      = sync_a_q[1];
    assign s_b      = sync_b_q[1];
    assign active_c = enable && (state_q != IDLE);
    assign strobe_c = active_c && (pcnt_q >= presc);
    // Effective level includes an acceptance that is about to reach qa/qb
    assign lvl_a_c  = qa_q ^ pend_a_q;
    assign lvl_b_c  = qb_q ^ pend_b_q;
    assign new_qa_c = ~qa_q;
    assign new_qb_c = ~qb_q;

    // State register
    always_ff @(posedge sys_clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = INIT;
            INIT:    if (strobe_c && (icnt_q == FLAST)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    // Prescaler, filters, seeding and event generation
    always_comb begin
        pcnt_d   = '0;
        fcnt_a_d = '0;
        fcnt_b_d = '0;
        icnt_d   = '0;
        pend_a_d = 1'b0;
        pend_b_d = 1'b0;
        qa_d     = qa_q;
        qb_d     = qb_q;
        step_d   = 1'b0;
        dir_d    = 1'b0;
        err_d    = 1'b0;
        if (active_c) begin
            pcnt_d = strobe_c ? '0 : pcnt_q + 1'b1;
            if (state_q == INIT) begin
                icnt_d = icnt_q;
                if (strobe_c) begin
                    qa_d   = s_a;
                    qb_d   = s_b;
                    icnt_d = icnt_q + 1'b1;
                end
            end else if (state_q == RUN) begin
                fcnt_a_d = fcnt_a_q;
                fcnt_b_d = fcnt_b_q;
                if (pend_a_q && pend_b_q) begin
                    qa_d  = new_qa_c;
                    qb_d  = new_qb_c;
                    err_d = 1'b1;
                end else if (pend_a_q) begin
                    qa_d   = new_qa_c;
                    step_d = 1'b1;
                    dir_d  = new_qa_c ^ qb_q;
                end else if (pend_b_q) begin
                    qb_d   = new_qb_c;
                    step_d = 1'b1;
                    dir_d  = ~(new_qb_c ^ qa_q);
                end
                if (strobe_c) begin
                    if (s_a == lvl_a_c) begin
                        fcnt_a_d = '0;
                    end else if (fcnt_a_q == FLAST) begin
                        fcnt_a_d = '0;
                        pend_a_d = 1'b1;
                    end else begin
                        fcnt_a_d = fcnt_a_q + 1'b1;
                    end
                    if (s_b == lvl_b_c) begin
                        fcnt_b_d = '0;
                    end else if (fcnt_b_q == FLAST) begin
                        fcnt_b_d = '0;
                        pend_b_d = 1'b1;
                    end else begin
                        fcnt_b_d = fcnt_b_q + 1'b1;
                    end
                end
            end
        end
        if (err_clr)                          err_cnt_d = '0;
        else if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        else                                  err_cnt_d = err_cnt_q;
    end

    // Datapath registers
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            pcnt_q    <= '0;
            fcnt_a_q  <= '0;
            fcnt_b_q  <= '0;
            icnt_q    <= '0;
            pend_a_q  <= 1'b0;
            pend_b_q  <= 1'b0;
            qa_q      <= 1'b0;
            qb_q      <= 1'b0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sync_a_q  <= {sync_a_q[0], PLUS_A};
            sync_b_q  <= {sync_b_q[0], PLUS_B};
            pcnt_q    <= pcnt_d;
            fcnt_a_q  <= fcnt_a_d;
            fcnt_b_q  <= fcnt_b_d;
            icnt_q    <= icnt_d;
            pend_a_q  <= pend_a_d;
            pend_b_q  <= pend_b_d;
            qa_q      <= qa_d;
            qb_q      <= qb_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign qa      = qa_q;
    assign qb      = qb_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_in_filter.sv
// Bench for quad_in_filter: directed scenarios plus random pin activity, all
// compared every clock against a window-based behavioural model.
module tb_quad_in_filter;

    localparam int F = 4;

    logic       sys_clock = 1'b0;
    logic       reset = 1'b1, enable = 1'b0, PLUS_A = 1'b0, PLUS_B = 1'b0, err_clr = 1'b0;
    logic [7:0] presc = 8'd0;
    logic       qa, qb, step, dir, err;
    logic [7:0] err_cnt;

    int n_checks = 0, n_pass = 0;
    int n_step = 0, n_up = 0, n_errs = 0, since_chg = 0, last_lat = -1;

    // Model: 0=idle 1=init 2=run; lv* is the accepted level, q* what the outputs show
    int m_state = 0, m_age = 0, m_inits = 0, m_errcnt = 0;
    bit m_a1 = 0, m_a2 = 0, m_b1 = 0, m_b2 = 0;
    bit m_qa = 0, m_qb = 0, m_lva = 0, m_lvb = 0, m_step = 0, m_dir = 0, m_err = 0;
    bit win_a[$], win_b[$];

    quad_in_filter #(.PRESC_BITS(8), .FILT_LEN(F)) dut (
        .sys_clock(sys_clock), .reset(reset), .enable(enable), .presc(presc),
        .PLUS_A(PLUS_A), .PLUS_B(PLUS_B), .err_clr(err_clr),
        .qa(qa), .qb(qb), .step(step), .dir(dir), .err(err), .err_cnt(err_cnt)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    endtask

    task automatic model_edge();
        bit sa, sb, pa, pb, strobe;
        int nd;
        sa = m_a2;
        sb = m_b2;
        m_step = 0; m_dir = 0; m_err = 0;
        if (reset) begin
            m_state = 0; m_age = 0; m_inits = 0; m_errcnt = 0;
            m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0;
            m_qa = 0; m_qb = 0; m_lva = 0; m_lvb = 0;
            win_a.delete(); win_b.delete();
        end else begin
            m_a2 = m_a1; m_a1 = PLUS_A;
            m_b2 = m_b1; m_b1 = PLUS_B;
            if (!enable || m_state == 0) begin
                m_lva = m_qa; m_lvb = m_qb;
                win_a.delete(); win_b.delete();
                m_age = 0; m_inits = 0;
                m_state = enable ? 1 : 0;
            end else begin
                if (m_state == 2) begin
                    pa = (m_lva != m_qa);
                    pb = (m_lvb != m_qb);
                    if (pa && pb) begin
                        m_qa = m_lva; m_qb = m_lvb; m_err = 1;
                    end else if (pa) begin
                        m_qa = m_lva; m_step = 1;
                        m_dir = (m_qa && !m_qb) || (!m_qa && m_qb);
                    end else if (pb) begin
                        m_qb = m_lvb; m_step = 1;
                        m_dir = (m_qb && m_qa) || (!m_qb && !m_qa);
                    end
                end
                m_age++;
                strobe = (m_age % (int'(presc) + 1)) == 0;
                if (strobe && m_state == 1) begin
                    m_qa = sa; m_qb = sb; m_lva = sa; m_lvb = sb;
                    m_inits++;
                    if (m_inits == F) m_state = 2;
                end else if (strobe && m_state == 2) begin
                    // A level is accepted once the last F strobes all disagree with it
                    win_a.push_back(sa); if (win_a.size() > F) void'(win_a.pop_front());
                    win_b.push_back(sb); if (win_b.size() > F) void'(win_b.pop_front());
                    nd = 0; foreach (win_a[k]) if (win_a[k] != m_lva) nd++;
                    if (nd == F) m_lva = !m_lva;
                    nd = 0; foreach (win_b[k]) if (win_b[k] != m_lvb) nd++;
                    if (nd == F) m_lvb = !m_lvb;
                end
            end
            if (err_clr) m_errcnt = 0;
            else if (m_err && m_errcnt < 255) m_errcnt++;
        end
    endtask

    task automatic tick();
        @(posedge sys_clock);
        model_edge();
        #1;
        since_chg++;
        if (step) begin n_step++; if (dir) n_up++; last_lat = since_chg; end
        if (err) n_errs++;
        check("cyc", {19'd0, qa, qb, step, dir, err, err_cnt},
                     {19'd0, m_qa, m_qb, m_step, m_dir, m_err, 8'(m_errcnt)});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_pins(input logic a, input logic b);
        PLUS_A = a;
        PLUS_B = b;
        since_chg = -1;
    endtask

    logic [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] dn_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic       clr_hit;

    initial begin
        run(3);
        check("rst_outs", {19'd0, qa, qb, step, dir, err, err_cnt}, 32'd0);

        // Seeding through INIT
        reset = 0; enable = 1; presc = 0;
        set_pins(1, 0);
        n_step = 0;
        run(30);
        check("seed_qa", qa, 1);
        check("seed_qb", qb, 0);
        check("seed_nostep", n_step, 0);

        // Forward and reverse quadrature cycles
        set_pins(0, 0); run(10);
        n_step = 0; n_up = 0;
        for (int i = 0; i < 4; i++) begin
            set_pins(up_seq[i][1], up_seq[i][0]);
            run(10);
            check("up_lat", 32'(last_lat), 6);
        end
        check("up_steps", n_step, 4);
        check("up_dir", n_up, 4);
        n_step = 0; n_up = 0;
        for (int i = 0; i < 4; i++) begin
            set_pins(dn_seq[i][1], dn_seq[i][0]);
            run(10);
        end
        check("dn_steps", n_step, 4);
        check("dn_dir", n_up, 0);

        // Glitches of F-1 clocks are dropped, F clocks pass
        n_step = 0; n_up = 0;
        repeat (3) begin
            set_pins(1, 0); run(3);
            set_pins(0, 0); run(10);
        end
        check("glitch_steps", n_step, 0);
        check("glitch_qa", qa, 0);
        set_pins(1, 0); run(4);
        set_pins(0, 0); run(12);
        check("pulse4_steps", n_step, 2);
        check("pulse4_up", n_up, 1);

        // Double transition
        n_step = 0; n_errs = 0;
        set_pins(1, 1); run(10);
        check("dbl_err", n_errs, 1);
        check("dbl_nostep", n_step, 0);
        check("dbl_q", {qa, qb}, 2'b11);
        check("dbl_cnt", err_cnt, 1);

        // Saturation, then clear coinciding with an err
        repeat (258) begin
            set_pins(!PLUS_A, !PLUS_B);
            run(8);
        end
        check("sat_cnt", err_cnt, 255);
        set_pins(!PLUS_A, !PLUS_B);
        clr_hit = 0;
        repeat (12) begin
            err_clr = (m_state == 2) && (m_lva != m_qa) && (m_lvb != m_qb);
            tick();
            if (err_clr && err) clr_hit = 1;
            err_clr = 0;
        end
        check("clr_hit", clr_hit, 1);
        check("clr_cnt", err_cnt, 0);

        // Prescaled latency
        enable = 0; run(2);
        presc = 3; enable = 1; run(40);
        n_step = 0; last_lat = -1;
        set_pins(!PLUS_A, PLUS_B); run(30);
        check("presc_steps", n_step, 1);
        check("presc_lat", (last_lat >= 14 && last_lat <= 18), 1);

        // Reset in the middle of a filter run
        set_pins(PLUS_A, !PLUS_B); run(8);
        reset = 1; n_step = 0;
        run(2);
        check("rst_mid_outs", {19'd0, qa, qb, step, dir, err, err_cnt}, 32'd0);
        check("rst_mid_nostep", n_step, 0);
        reset = 0; run(30);

        // Random pin activity with occasional enable drops, clears and resets
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                reset = 1; run(1); reset = 0;
            end else if (r < 9) begin
                enable = 0; presc = 8'($urandom_range(0, 3));
                run($urandom_range(1, 3));
                enable = 1;
            end
            set_pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            err_clr = ($urandom_range(0, 19) == 0);
            run(1);
            err_clr = 0;
            run($urandom_range(0, 11));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
